// File: rtl/sync_multi_filt.sv
// Multi-channel asynchronous-input synchronizer with a per-channel glitch filter
// and registered rise/fall/any_edge event pulses.
module sync_multi_filt #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  logic [WIDTH-1:0] raw;

  always_comb begin
    chain_d[0] = async_in;
    for (int k = 1; k < STAGES; k++) chain_d[k] = chain_q[k-1];
  end

  assign raw = chain_q[STAGES-1];

  // A channel commits only after FILTER_LEN consecutive differing samples;
  // any agreeing sample in between discards the partial count.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sync_d = sync_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == sync_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sync_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rise_d = sync_d & ~sync_q;
    fall_d = ~sync_d & sync_q;
    any_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the chain and counter arrays are small flop banks, not RAM, so they
      // are reset element by element to keep the reset state fully defined.
      for (int k = 0; k < STAGES; k++) chain_q[k] <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++)  cnt_q[i]   <= '0;
      sync_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int k = 0; k < STAGES; k++) chain_q[k] <= chain_d[k];
      for (int i = 0; i < WIDTH; i++)  cnt_q[i]   <= cnt_d[i];
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign any_edge = any_q;

endmodule

// File: tb/tb_sync_multi_filt.sv
// Scoreboard bench for sync_multi_filt: three instances (defaults, FILTER_LEN=3,
// RESET_VAL=4'b1010); stimulus pushes expected events, per-DUT monitors pop them.
module tb_sync_multi_filt;

  typedef struct {
    int         cyc;
    logic [3:0] so;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_pass = 0;
  int n_checks = 0;
  exp_t sb[3][$];

  logic       rst_a, rst_b, rst_c;
  logic [3:0] in_a, in_b, in_c;
  logic [3:0] so_a, so_b, so_c, r_a, r_b, r_c, f_a, f_b, f_c;
  logic       ae_a, ae_b, ae_c;

  sync_multi_filt u_def (
    .clk(clk), .rst(rst_a), .async_in(in_a),
    .sync_out(so_a), .rise(r_a), .fall(f_a), .any_edge(ae_a));

  sync_multi_filt #(.FILTER_LEN(3)) u_f3 (
    .clk(clk), .rst(rst_b), .async_in(in_b),
    .sync_out(so_b), .rise(r_b), .fall(f_b), .any_edge(ae_b));

  sync_multi_filt #(.RESET_VAL(4'b1010)) u_rv (
    .clk(clk), .rst(rst_c), .async_in(in_c),
    .sync_out(so_c), .rise(r_c), .fall(f_c), .any_edge(ae_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int id, input int dly, input logic [3:0] so,
                      input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc = cyc + dly;
    e.so  = so;
    e.r   = r;
    e.f   = f;
    sb[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic [3:0] so, input logic [3:0] r,
                     input logic [3:0] f, input logic ae);
    exp_t e;
    if (ae === 1'b1 || (|r) === 1'b1 || (|f) === 1'b1) begin
      if (sb[id].size() == 0) begin
        check($sformatf("unexpected_pulse_dut%0d", id), {23'd0, ae, r, f}, 32'd0);
      end else begin
        e = sb[id].pop_front();
        check($sformatf("pulse_cycle_dut%0d", id), e.cyc, cyc);
        check($sformatf("sync_out_dut%0d", id), {28'd0, so}, {28'd0, e.so});
        check($sformatf("rise_dut%0d", id), {28'd0, r}, {28'd0, e.r});
        check($sformatf("fall_dut%0d", id), {28'd0, f}, {28'd0, e.f});
        check($sformatf("any_edge_dut%0d", id), {31'd0, ae}, 32'd1);
      end
    end
  endtask

  always @(negedge clk) mon(0, so_a, r_a, f_a, ae_a);
  always @(negedge clk) mon(1, so_b, r_b, f_b, ae_b);
  always @(negedge clk) mon(2, so_c, r_c, f_c, ae_c);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; in_a = 4'hF;
    rst_b = 1'b1; in_b = 4'h0;
    rst_c = 1'b1; in_c = 4'b1010;
    #1;
    // Asynchronous reset must be visible before any clock edge
    check("async_reset_a", {28'd0, so_a}, 32'h0);
    check("async_reset_c", {28'd0, so_c}, 32'hA);

    // Test 1: reset held over two clocks, then release with inputs all high
    step(2);
    check("reset_so_a", {28'd0, so_a}, 32'h0);
    check("reset_pulses_a", {23'd0, ae_a, r_a, f_a}, 32'd0);
    check("reset_so_c", {28'd0, so_c}, 32'hA);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    push(0, 3, 4'hF, 4'hF, 4'h0);
    step(2);
    check("t1_not_before_edge3", {28'd0, so_a}, 32'h0);
    step(3);
    check("t1_level", {28'd0, so_a}, 32'hF);

    // Test 2: latency with default parameters
    in_a = 4'h0;
    push(0, 3, 4'h0, 4'h0, 4'hF);
    step(5);
    in_a = 4'h1;
    push(0, 3, 4'h1, 4'h1, 4'h0);
    step(2);
    check("t2_not_at_edge2", {31'd0, so_a[0]}, 32'd0);
    step(1);
    check("t2_at_edge3", {31'd0, so_a[0]}, 32'd1);
    step(3);

    // Test 4: simultaneous rise and fall on different channels
    in_a = 4'b0100;
    push(0, 3, 4'b0100, 4'b0100, 4'b0001);
    step(5);
    in_a = 4'b0001;
    push(0, 3, 4'b0001, 4'b0001, 4'b0100);
    step(5);

    // Toggle every cycle (FILTER_LEN=1): alternating pulses, none dropped
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) begin
        in_a = 4'b1001;
        push(0, 3, 4'b1001, 4'b1000, 4'b0000);
      end else begin
        in_a = 4'b0001;
        push(0, 3, 4'b0001, 4'b0000, 4'b1000);
      end
      step(1);
    end
    step(5);

    // Test 3: FILTER_LEN=3 glitch rejection then a held level
    in_b = 4'b0010;
    step(2);
    in_b = 4'b0000;
    step(8);
    check("t3_glitch_rejected", {28'd0, so_b}, 32'h0);
    in_b = 4'b0010;
    push(1, 5, 4'b0010, 4'b0010, 4'b0000);
    step(4);
    check("t3_not_at_edge4", {31'd0, so_b[1]}, 32'd0);
    step(1);
    check("t3_at_edge5", {31'd0, so_b[1]}, 32'd1);
    step(3);
    in_b = 4'b0000;
    push(1, 5, 4'b0000, 4'b0000, 4'b0010);
    step(7);

    // Test 5: reset one cycle before the filter would commit
    in_b = 4'b0010;
    step(4);
    rst_b = 1'b1;
    step(1);
    check("t5_reset_discards", {28'd0, so_b}, 32'h0);
    step(1);
    rst_b = 1'b0;
    push(1, 5, 4'b0010, 4'b0010, 4'b0000);
    step(4);
    check("t5_full_latency_not_edge4", {28'd0, so_b}, 32'h0);
    step(1);
    check("t5_full_latency_edge5", {28'd0, so_b}, 32'h2);
    step(3);

    // Test 6: RESET_VAL=4'b1010 with matching input held 20 cycles after release
    check("t6_hold_before", {28'd0, so_c}, 32'hA);
    step(20);
    check("t6_hold_after", {28'd0, so_c}, 32'hA);

    step(2);
    for (int i = 0; i < 3; i++)
      check($sformatf("scoreboard_drained_dut%0d", i), sb[i].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
